zint_gen: RTL and testbench



---
 rtl/zxiznet_int_pkg.sv | 16 +
 rtl/int_sync.sv | 25 ++
 rtl/zint_gen.sv | 130 +++++++++++++
 tb/tb_zint_gen.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/zxiznet_int_pkg.sv
// rtl/zxiznet_int_pkg.sv - shared types and source indices for the ZX-bus INT path
package zxiznet_int_pkg;

  // Pulse generator states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    HOLDOFF = 2'd2
  } zint_state_e;

  // Interrupt source bit positions in src_lvl / pending / clr_data
  localparam int SRC_W5300 = 0;
  localparam int SRC_SL811 = 1;
  localparam int NSRC      = 2;

endpackage

// File: rtl/int_sync.sv
// rtl/int_sync.sv - multi-flop synchroniser for one asynchronous interrupt pin
module int_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  // Shift the pin in; reset holds the chain at the source's inactive level
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= {STAGES{RST_VAL}};
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/zint_gen.sv
// rtl/zint_gen.sv - interrupt sync, W1C pending, masking and rate-limited INT pulse
module zint_gen
  import zxiznet_int_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_LEN   = 32,
  parameter int HOLDOFF_LEN = 64,
  parameter int CNT_W       = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            w5300_int_n,
  input  logic            sl811_intrq,
  input  logic            ena_w5300_int,
  input  logic            ena_sl811_int,
  input  logic            ena_zxbus_int,
  input  logic            clr_wr,
  input  logic [NSRC-1:0] clr_data,
  output logic [NSRC-1:0] src_lvl,
  output logic [NSRC-1:0] pending,
  output logic            internal_int,
  output logic            zint_req
);

  // Counter reload values; lengths of 2^CNT_W still fit after the -1
  localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] HOLDOFF_LOAD = CNT_W'(HOLDOFF_LEN - 1);

  logic            w5300_sync;
  logic            sl811_sync;
  logic [NSRC-1:0] src_d_q;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] clr_mask;
  logic [NSRC-1:0] pending_q, pending_d;
  zint_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            zint_req_q, zint_req_d;

  // W5300 is active-low, so its chain idles high and is inverted afterwards
  int_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync_w5300 (
    .clk (clk),
    .rst (rst),
    .d_i (w5300_int_n),
    .q_o (w5300_sync)
  );

  int_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_sync_sl811 (
    .clk (clk),
    .rst (rst),
    .d_i (sl811_intrq),
    .q_o (sl811_sync)
  );

  assign src_lvl[SRC_W5300] = ~w5300_sync;
  assign src_lvl[SRC_SL811] = sl811_sync;

  // Only a fresh assertion sets a flag, so clearing a held source sticks
  assign rise      = src_lvl & ~src_d_q;
  assign clr_mask  = clr_wr ? clr_data : '0;
  assign pending_d = (pending_q & ~clr_mask) | rise;

  assign pending      = pending_q;
  assign internal_int = |(pending_q & {ena_sl811_int, ena_w5300_int});
  assign zint_req     = zint_req_q;

  // Edge history and write-1-to-clear pending flags (set wins over clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      src_d_q   <= '0;
      pending_q <= '0;
    end else begin
      src_d_q   <= src_lvl;
      pending_q <= pending_d;
    end
  end

  // Pulse/holdoff sequencing on a single shared down-counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (internal_int && ena_zxbus_int) begin
          state_d = PULSE;
          cnt_d   = PULSE_LOAD;
        end
      end
      PULSE: begin
        if ((cnt_q == '0) || !ena_zxbus_int) begin
          state_d = HOLDOFF;
          cnt_d   = HOLDOFF_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLDOFF: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    zint_req_d = (state_d == PULSE);
  end

  // FSM state, counter and the registered bus request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      zint_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      zint_req_q <= zint_req_d;
    end
  end

endmodule

// File: tb/tb_zint_gen.sv
// tb/tb_zint_gen.sv - self-checking bench for zint_gen with a pulse scoreboard
module tb_zint_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       w5300_int_n;
  logic       sl811_intrq;
  logic       ena_w5300_int;
  logic       ena_sl811_int;
  logic       ena_zxbus_int;
  logic       clr_wr;
  logic [1:0] clr_data;
  logic [1:0] src_lvl;
  logic [1:0] pending;
  logic       internal_int;
  logic       zint_req;

  int    cyc      = 0;
  int    n_checks = 0;
  int    n_pass   = 0;
  int    exp_start_q[$];
  int    exp_len_q[$];
  string exp_tag_q[$];
  logic  req_prev = 1'b0;
  int    p_start  = 0;
  int    t0, t1, t2;

  zint_gen #(
    .SYNC_STAGES (2),
    .PULSE_LEN   (32),
    .HOLDOFF_LEN (64),
    .CNT_W       (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .w5300_int_n   (w5300_int_n),
    .sl811_intrq   (sl811_intrq),
    .ena_w5300_int (ena_w5300_int),
    .ena_sl811_int (ena_sl811_int),
    .ena_zxbus_int (ena_zxbus_int),
    .clr_wr        (clr_wr),
    .clr_data      (clr_data),
    .src_lvl       (src_lvl),
    .pending       (pending),
    .internal_int  (internal_int),
    .zint_req      (zint_req)
  );

  always #5 clk = ~clk;

  // Edge counter: after the k-th rising edge, cyc reads k
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic expect_pulse(input string tag, input int start, input int len);
    exp_tag_q.push_back(tag);
    exp_start_q.push_back(start);
    exp_len_q.push_back(len);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Pulse monitor: measures each zint_req pulse and retires one expectation
  always @(negedge clk) begin
    string tag;
    int    es, el;
    if (zint_req === 1'b1 && !req_prev) p_start = cyc;
    if (zint_req !== 1'b1 && req_prev) begin
      check("pulse_has_expectation", int'(exp_start_q.size() > 0), 1);
      if (exp_start_q.size() > 0) begin
        tag = exp_tag_q.pop_front();
        es  = exp_start_q.pop_front();
        el  = exp_len_q.pop_front();
        check($sformatf("%s_start", tag), p_start, es);
        check($sformatf("%s_len", tag), cyc - p_start, el);
      end
    end
    req_prev = (zint_req === 1'b1);
  end

  initial begin
    rst           = 1'b1;
    w5300_int_n   = 1'b1;
    sl811_intrq   = 1'b0;
    ena_w5300_int = 1'b0;
    ena_sl811_int = 1'b0;
    ena_zxbus_int = 1'b0;
    clr_wr        = 1'b0;
    clr_data      = 2'b00;
    tick(3);
    check("rst_zint_req", zint_req, 0);
    check("rst_pending", pending, 0);
    check("rst_src_lvl", src_lvl, 0);
    check("rst_internal", internal_int, 0);
    rst = 1'b0;
    tick(2);

    // Basic pulse and retrigger until cleared
    ena_w5300_int = 1'b1;
    ena_sl811_int = 1'b1;
    ena_zxbus_int = 1'b1;
    tick(2);
    check("idle_no_req", zint_req, 0);
    w5300_int_n = 1'b0;
    t0 = cyc;
    expect_pulse("basic", t0 + 4, 32);
    expect_pulse("retrig", t0 + 101, 32);
    tick(2);
    check("w5300_src_lvl", src_lvl, 2'b01);
    check("pend_before_edge3", pending, 0);
    tick(1);
    check("w5300_pending", pending, 2'b01);
    check("w5300_internal", internal_int, 1);
    check("req_low_edge3", zint_req, 0);
    tick(1);
    check("req_high_edge4", zint_req, 1);
    wait_until(t0 + 35);
    check("req_high_edge35", zint_req, 1);
    tick(1);
    check("req_low_edge36", zint_req, 0);
    wait_until(t0 + 140);
    clr_wr = 1'b1; clr_data = 2'b01;
    tick(1);
    clr_wr = 1'b0; clr_data = 2'b00;
    check("clr_pending", pending, 0);
    check("clr_internal", internal_int, 0);
    wait_until(t0 + 260);
    check("no_pulse_after_clr", zint_req, 0);
    w5300_int_n = 1'b1;
    tick(4);

    // Masking: pending latches, INT waits for the enable
    ena_sl811_int = 1'b0;
    sl811_intrq   = 1'b1;
    tick(3);
    check("mask_pending", pending, 2'b10);
    check("mask_internal", internal_int, 0);
    tick(10);
    check("mask_no_req", zint_req, 0);
    ena_sl811_int = 1'b1;
    t1 = cyc;
    expect_pulse("unmask", t1 + 1, 32);
    tick(1);
    check("unmask_req", zint_req, 1);
    tick(1);
    clr_wr = 1'b1; clr_data = 2'b10;
    tick(1);
    clr_wr = 1'b0; clr_data = 2'b00;
    check("unmask_clr", pending, 0);
    sl811_intrq = 1'b0;
    wait_until(t1 + 100);
    check("unmask_done", zint_req, 0);

    // Set/clear collision, bus INT disabled so no pulses
    ena_zxbus_int = 1'b0;
    sl811_intrq   = 1'b1;
    tick(3);
    check("nobus_pending", pending, 2'b10);
    check("nobus_req", zint_req, 0);
    sl811_intrq = 1'b0;
    w5300_int_n = 1'b0;
    tick(2);
    clr_wr = 1'b1; clr_data = 2'b11;
    tick(1);
    clr_wr = 1'b0; clr_data = 2'b00;
    check("collision", pending, 2'b01);
    clr_wr = 1'b1; clr_data = 2'b01;
    tick(1);
    clr_wr = 1'b0; clr_data = 2'b00;
    check("clr_held_src", pending, 0);
    tick(5);
    check("no_reset_while_held", pending, 0);
    w5300_int_n = 1'b1;
    tick(4);

    // Abort by master enable, then holdoff before the next pulse
    ena_zxbus_int = 1'b1;
    tick(1);
    w5300_int_n = 1'b0;
    t0 = cyc;
    expect_pulse("abort", t0 + 4, 7);
    expect_pulse("post_holdoff", t0 + 76, 32);
    wait_until(t0 + 10);
    check("abort_pre", zint_req, 1);
    ena_zxbus_int = 1'b0;
    tick(1);
    check("abort_req_low", zint_req, 0);
    tick(1);
    ena_zxbus_int = 1'b1;
    wait_until(t0 + 75);
    check("holdoff_held", zint_req, 0);
    tick(1);
    check("holdoff_retrig", zint_req, 1);
    wait_until(t0 + 80);
    clr_wr = 1'b1; clr_data = 2'b01;
    tick(1);
    clr_wr = 1'b0; clr_data = 2'b00;
    w5300_int_n = 1'b1;
    wait_until(t0 + 180);

    // Reset mid-pulse, and a source held through reset release
    sl811_intrq = 1'b1;
    t1 = cyc;
    expect_pulse("rst_cut", t1 + 4, 7);
    wait_until(t1 + 10);
    check("rst_pre_req", zint_req, 1);
    rst = 1'b1;
    tick(1);
    check("rst_mid_req", zint_req, 0);
    check("rst_mid_pending", pending, 0);
    check("rst_mid_src", src_lvl, 0);
    tick(1);
    rst = 1'b0;
    t2 = cyc;
    expect_pulse("after_rst", t2 + 4, 32);
    tick(2);
    check("rel_pend_edge2", pending, 0);
    tick(1);
    check("rel_pend_edge3", pending, 2'b10);
    wait_until(t2 + 10);
    clr_wr = 1'b1; clr_data = 2'b10;
    tick(1);
    clr_wr = 1'b0; clr_data = 2'b00;
    sl811_intrq = 1'b0;
    wait_until(t2 + 120);
    check("final_req", zint_req, 0);
    check("final_pending", pending, 0);
    check("scoreboard_drained", exp_start_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
